// File: rtl/x_feed_pkg.sv
// Shared types and defaults for the X feed buffer that sits in front of the
// squaring compute unit.
package x_feed_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_W_DEF    = 11;
    localparam int MAX_N      = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        DONE = 2'd2
    } feed_state_e;

endpackage

// File: rtl/x_feed_buf_sync_fifo.sv
// Single-clock FIFO with flush; full/empty are decoded from the registered
// occupancy so neither depends on push or pop in the same cycle.
module sync_fifo
    import x_feed_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/x_feed_buf.sv
// Buffers processor-written X words and feeds them to the compute unit,
// counting deliveries against the run length N.
module x_feed_buf
    import x_feed_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 16,
    parameter int N_W    = N_W_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_W-1:0]    N_in,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              x_valid,
    output logic [DATA_W-1:0] x_data,
    input  logic              x_ready,
    output logic [N_W-1:0]    N_out,
    output logic [N_W-1:0]    sent_cnt,
    output logic              feed_done,
    output logic              busy,
    output logic              err
);

    feed_state_e       state_q, state_d;
    logic [N_W-1:0]    n_q, n_d;
    logic [N_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [N_W-1:0]    sent_cnt_q, sent_cnt_d;
    logic [N_W-1:0]    sent_inc;
    logic              err_q, err_d;
    logic              fifo_push, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic [AW:0]       fifo_count;
    logic              xfer;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (xfer),
        .flush (start),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Outputs decode registered state only; x_ready/wr_en never reach them.
    assign busy      = (state_q == FEED);
    assign feed_done = (state_q == DONE);
    assign x_valid   = busy && (fifo_count != '0);
    assign x_data    = fifo_empty ? '0 : fifo_dout;
    assign wr_full   = fifo_full;
    assign N_out     = n_q;
    assign sent_cnt  = sent_cnt_q;
    assign err       = err_q;
    assign xfer      = x_valid && x_ready;
    assign sent_inc  = sent_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        acc_cnt_d  = acc_cnt_q;
        sent_cnt_d = sent_cnt_q;
        err_d      = err_q;
        fifo_push  = 1'b0;
        if (start) begin
            // A restart wins over everything else, including a write in the same cycle.
            n_d        = N_in;
            acc_cnt_d  = '0;
            sent_cnt_d = '0;
            err_d      = 1'b0;
            state_d    = (N_in == '0) ? DONE : FEED;
        end else begin
            if (wr_en) begin
                if (busy && !fifo_full && (acc_cnt_q < n_q)) begin
                    fifo_push = 1'b1;
                    acc_cnt_d = acc_cnt_q + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            if (xfer) begin
                sent_cnt_d = sent_inc;
                if (sent_inc == n_q) state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            acc_cnt_q  <= '0;
            sent_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            acc_cnt_q  <= acc_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_x_feed_buf.sv
// Directed bench for x_feed_buf; inputs change 1 ns after the rising edge and
// outputs are checked at that same point, away from the active edge.
module tb_x_feed_buf;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int N_W    = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [N_W-1:0]    N_in;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic              x_valid;
    logic [DATA_W-1:0] x_data;
    logic              x_ready;
    logic [N_W-1:0]    N_out;
    logic [N_W-1:0]    sent_cnt;
    logic              feed_done;
    logic              busy;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;

    x_feed_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .N_W(N_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .N_in      (N_in),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .x_valid   (x_valid),
        .x_data    (x_data),
        .x_ready   (x_ready),
        .N_out     (N_out),
        .sent_cnt  (sent_cnt),
        .feed_done (feed_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [N_W-1:0] n);
        start = 1'b1;
        N_in  = n;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".wr_full"},   32'(wr_full),   32'd0);
        check({tag, ".x_valid"},   32'(x_valid),   32'd0);
        check({tag, ".x_data"},    x_data,         32'd0);
        check({tag, ".N_out"},     32'(N_out),     32'd0);
        check({tag, ".sent_cnt"},  32'(sent_cnt),  32'd0);
        check({tag, ".feed_done"}, 32'(feed_done), 32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".err"},       32'(err),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfers;
        reset   = 1'b1;
        start   = 1'b0;
        N_in    = '0;
        wr_en   = 1'b0;
        wr_data = '0;
        x_ready = 1'b0;
        #3;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b0;
        tick();

        // N=4: each word appears one cycle after its write and is taken at once.
        do_start(11'd4);
        check("t1.busy", 32'(busy), 32'd1);
        check("t1.N_out", 32'(N_out), 32'd4);
        check("t1.valid_after_start", 32'(x_valid), 32'd0);
        x_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'(i);
            tick();
            check("t1.x_valid", 32'(x_valid), 32'd1);
            check("t1.x_data", x_data, 32'(i));
            check("t1.sent", 32'(sent_cnt), 32'(i - 1));
        end
        wr_en = 1'b0;
        tick();
        check("t1.sent_final", 32'(sent_cnt), 32'd4);
        check("t1.feed_done", 32'(feed_done), 32'd1);
        check("t1.busy_done", 32'(busy), 32'd0);
        check("t1.x_valid_done", 32'(x_valid), 32'd0);
        check("t1.err", 32'(err), 32'd0);

        // N=20 with the consumer stalled: fill, overflow, then drain at full rate.
        x_ready = 1'b0;
        do_start(11'd20);
        for (int i = 0; i < 17; i++) begin
            check("t2.wr_full_fill", 32'(wr_full), (i >= 16) ? 32'd1 : 32'd0);
            wr_en   = 1'b1;
            wr_data = 32'h100 + 32'(i);
            tick();
        end
        wr_en = 1'b0;
        check("t2.err_overflow", 32'(err), 32'd1);
        check("t2.wr_full", 32'(wr_full), 32'd1);
        x_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t2.drain_valid", 32'(x_valid), 32'd1);
            check("t2.drain_data", x_data, 32'h100 + 32'(i));
            tick();
        end
        check("t2.empty_after", 32'(x_valid), 32'd0);
        check("t2.sent", 32'(sent_cnt), 32'd16);
        check("t2.not_full", 32'(wr_full), 32'd0);
        check("t2.still_busy", 32'(busy), 32'd1);

        // N=3 with four writes: the fourth exceeds N and is dropped.
        x_ready = 1'b0;
        do_start(11'd3);
        check("t3.err_cleared", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'hA + 32'(i);
            tick();
        end
        wr_en = 1'b0;
        check("t3.err", 32'(err), 32'd1);
        x_ready = 1'b1;
        xfers = 0;
        for (int c = 0; c < 8; c++) begin
            if (x_valid) begin
                check("t3.data", x_data, 32'hA + 32'(xfers));
                xfers++;
            end
            tick();
        end
        check("t3.xfers", 32'(xfers), 32'd3);
        check("t3.sent", 32'(sent_cnt), 32'd3);
        check("t3.feed_done", 32'(feed_done), 32'd1);

        // N=0 goes straight to DONE; a write there flags an error.
        do_start(11'd0);
        check("t4.feed_done", 32'(feed_done), 32'd1);
        check("t4.busy", 32'(busy), 32'd0);
        check("t4.x_valid", 32'(x_valid), 32'd0);
        check("t4.err_clear", 32'(err), 32'd0);
        wr_en   = 1'b1;
        wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        check("t4.err_write", 32'(err), 32'd1);
        check("t4.x_valid_after", 32'(x_valid), 32'd0);
        check("t4.done_hold", 32'(feed_done), 32'd1);

        // N=8 restarted mid-run with N=2; the write in the start cycle is silently dropped.
        x_ready = 1'b0;
        do_start(11'd8);
        check("t5.err_clear", 32'(err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h20 + 32'(i);
            tick();
        end
        wr_en   = 1'b0;
        x_ready = 1'b1;
        tick();
        tick();
        tick();
        x_ready = 1'b0;
        check("t5.sent3", 32'(sent_cnt), 32'd3);
        check("t5.head", x_data, 32'h23);
        wr_en   = 1'b1;
        wr_data = 32'hFF;
        do_start(11'd2);
        wr_en = 1'b0;
        check("t5.sent_clr", 32'(sent_cnt), 32'd0);
        check("t5.err_clr", 32'(err), 32'd0);
        check("t5.N_out", 32'(N_out), 32'd2);
        check("t5.flushed", 32'(x_valid), 32'd0);
        check("t5.busy", 32'(busy), 32'd1);
        x_ready = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h30 + 32'(i);
            tick();
            check("t5.x_data", x_data, 32'h30 + 32'(i));
        end
        wr_en = 1'b0;
        tick();
        check("t5.done", 32'(feed_done), 32'd1);
        check("t5.sent2", 32'(sent_cnt), 32'd2);
        check("t5.err_final", 32'(err), 32'd0);

        // Asynchronous reset with five words buffered mid-run.
        x_ready = 1'b0;
        do_start(11'd10);
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h40 + 32'(i);
            tick();
        end
        wr_en = 1'b0;
        check("t6.pre_valid", 32'(x_valid), 32'd1);
        check("t6.pre_data", x_data, 32'h40);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t6.async");
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t6.idle_valid", 32'(x_valid), 32'd0);
        check("t6.idle_busy", 32'(busy), 32'd0);
        tick();
        check("t6.idle_valid2", 32'(x_valid), 32'd0);
        x_ready = 1'b1;
        do_start(11'd1);
        wr_en   = 1'b1;
        wr_data = 32'h77;
        tick();
        wr_en = 1'b0;
        check("t6.post_data", x_data, 32'h77);
        tick();
        check("t6.post_done", 32'(feed_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/x_feed_buf.md
# x_feed_buf

Upstream feeder for the squaring compute unit. It takes X words written one at a time by the processor through the memory-mapped register slave, buffers them in a small FIFO, and presents them to the compute unit over a valid/ready handshake. It tracks the number of words delivered against the programmed element count N and reports status back to the register file.

## Interface
- DATA_W, 32, width of one X word
- DEPTH, 16, FIFO depth in words; power of two, ≥2
- N_W, 11, width of element count; N range 0..1024
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; latches N_in, flushes FIFO, clears counters/flags
- N_in  in  N_W  element count for the run
- wr_en  in  1  register-slave write strobe for the X data register
- wr_data  in  DATA_W  X word being written
- wr_full  out  1  FIFO full
- x_valid  out  1  X word available to compute unit
- x_data  out  DATA_W  head-of-FIFO word
- x_ready  in  1  compute unit accepts x_data this cycle
- N_out  out  N_W  latched N, drives compute unit N input
- sent_cnt  out  N_W  words delivered this run
- feed_done  out  1  all N words delivered
- busy  out  1  run in progress (FEED state)
- err  out  1  sticky: a write was dropped

## Operation
- States: IDLE, FEED, DONE. Reset → IDLE.
- IDLE: start → FEED; if N_in==0, start → DONE directly.
- FEED: write accepted iff wr_en && !wr_full && acc_cnt<N_out; acc_cnt +1. Any other wr_en sets err and drops the word.
- Transfer = x_valid && x_ready; pops FIFO, sent_cnt +1.
- FEED → DONE on the cycle the transfer making sent_cnt==N_out is registered.
- DONE: feed_done=1, holds until start. start from DONE behaves as from IDLE.
- start in any state, including mid-FEED: FIFO flushed, acc_cnt, sent_cnt and err cleared, N re-latched, same cycle-level outcome as from IDLE; wr_en in the start cycle is dropped without setting err.
- wr_en in IDLE/DONE: dropped, err=1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.

## Timing
- Reset values: wr_full=0, x_valid=0, x_data=0, N_out=0, sent_cnt=0, feed_done=0, busy=0, err=0.
- All outputs are registered or decoded from registered state only; no combinational path from x_ready or wr_en to any output.
- Write-to-valid latency: word written in cycle t is visible on x_valid/x_data at t+1 when the FIFO was empty. No bypass.
- x_data is stable while x_valid && !x_ready.
- Full: wr_full reflects the registered occupancy. A write in a cycle with wr_full=1 is dropped (err=1) even if a pop occurs in the same cycle.
- Empty with simultaneous write: the word appears the next cycle; no pop occurs.
- Simultaneous write and pop when neither full nor empty: occupancy unchanged, both complete.
- Throughput: one transfer per cycle when x_ready is held high and the FIFO is non-empty.
- busy=1 exactly in FEED. feed_done rises the cycle after the final transfer.
- x_valid is 0 in IDLE/DONE and in the cycle after start.

## Structure
- Package x_feed_pkg: state enum (IDLE=0, FEED=1, DONE=2, 2-bit), DATA_W and N_W defaults, MAX_N=1024.
- One sub-module, sync_fifo (DATA_W, DEPTH): push, pop, flush, dout, full, empty, count.
- Top holds the FSM, acc_cnt, sent_cnt, err and the N latch.

## Test plan
- N=4, DEPTH=16, write 0x1,0x2,0x3,0x4 with x_ready=1 → x_data sequence 1,2,3,4 each one cycle after its write; sent_cnt=4; feed_done=1 one cycle after the last transfer; err=0.
- N=20, x_ready=0, 17 back-to-back writes → wr_full=1 after the 16th; 17th dropped, err=1. Then x_ready=1 → 16 words drained in 16 consecutive cycles in order.
- N=3, 4 writes → 4th dropped, err=1; exactly 3 transfers; feed_done=1.
- N=0 start → DONE next cycle, feed_done=1, x_valid stays 0; a write there sets err=1.
- N=8, start pulsed again after 3 transfers with N_in=2 → FIFO empty, sent_cnt=0, err=0, N_out=2; 2 new words complete the run.
- Assert reset mid-FEED with 5 words buffered → all outputs at reset values asynchronously. After release, state=IDLE and x_valid=0 until the next start.
